// File: rtl/display_scan.sv
// display_scan: time-multiplexed driver for a 4-digit 7-segment display.
// It scans one digit slot per REFRESH_DIV clocks. It also captures a
// per-frame snapshot of the BCD inputs. Slot 2 gets a decimal point, which
// blinks while the stopwatch is running.
module display_scan #(
  parameter int REFRESH_DIV = 50000,
  parameter int BLINK_DIV   = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] s0,
  input  logic [3:0] s1,
  input  logic [3:0] m0,
  input  logic [3:0] m1,
  input  logic       running,
  input  logic       blank_lead,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_done
);

  localparam int CW = $clog2(REFRESH_DIV);
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [CW-1:0] cnt_reg, cnt_next;
  logic [1:0]    slot_reg, slot_next;
  logic [BW-1:0] frame_cnt_reg, frame_cnt_next;
  logic          blink_phase_reg, blink_phase_next;
  logic [3:0]    digit_in [4];
  logic [3:0]    snap_reg [4];
  logic [3:0]    an_next;
  logic [6:0]    seg_next;
  logic          dp_next;
  logic          cnt_last;
  logic          guard;
  logic [3:0]    cur_digit;

  // Slot order matches the anode order: slot 0 is s0, slot 3 is m1.
  assign digit_in[0] = s0;
  assign digit_in[1] = s1;
  assign digit_in[2] = m0;
  assign digit_in[3] = m1;

  // The frame ends on the last count of slot 3. The snapshot is captured
  // on the same edge.
  assign cnt_last   = (cnt_reg == CW'(REFRESH_DIV - 1));
  assign frame_done = cnt_last && (slot_reg == 2'd3);

  // Next-state logic for the refresh counter, the slot index and the blink divider.
  always_comb begin
    cnt_next         = cnt_reg + CW'(1);
    slot_next        = slot_reg;
    frame_cnt_next   = frame_cnt_reg;
    blink_phase_next = blink_phase_reg;
    if (cnt_last) begin
      cnt_next  = '0;
      slot_next = slot_reg + 2'd1;
    end
    if (frame_done) begin
      if (frame_cnt_reg == BW'(BLINK_DIV - 1)) begin
        frame_cnt_next   = '0;
        blink_phase_next = ~blink_phase_reg;
      end else begin
        frame_cnt_next = frame_cnt_reg + BW'(1);
      end
    end
  end

  // Update the counter, slot and blink state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_reg         <= '0;
      slot_reg        <= '0;
      frame_cnt_reg   <= '0;
      blink_phase_reg <= 1'b0;
    end else begin
      cnt_reg         <= cnt_next;
      slot_reg        <= slot_next;
      frame_cnt_reg   <= frame_cnt_next;
      blink_phase_reg <= blink_phase_next;
    end
  end

  // Each snapshot digit is reloaded only at the frame boundary, so a frame
  // never mixes old and new input values.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_snap
      // Capture one snapshot digit on each frame wrap.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) snap_reg[gi] <= 4'd0;
        else if (frame_done) snap_reg[gi] <= digit_in[gi];
      end
    end
  endgenerate

  // For the first two counts of a slot all anodes are off. This hides
  // ghosting from the previous digit's segments.
  assign guard     = (cnt_reg <= CW'(1));
  assign cur_digit = snap_reg[slot_reg];

  generate
    for (gi = 0; gi < 4; gi++) begin : g_an
      assign an_next[gi] = guard | (slot_reg != 2'(gi));
    end
  endgenerate

  // Decode the current digit to segments and select the decimal point.
  always_comb begin
    seg_next = 7'b0111111;
    case (cur_digit)
      4'd0: seg_next = 7'b1000000;
      4'd1: seg_next = 7'b1111001;
      4'd2: seg_next = 7'b0100100;
      4'd3: seg_next = 7'b0110000;
      4'd4: seg_next = 7'b0011001;
      4'd5: seg_next = 7'b0010010;
      4'd6: seg_next = 7'b0000010;
      4'd7: seg_next = 7'b1111000;
      4'd8: seg_next = 7'b0000000;
      4'd9: seg_next = 7'b0010000;
      default: seg_next = 7'b0111111;
    endcase
    if ((slot_reg == 2'd3) && blank_lead && (cur_digit == 4'd0))
      seg_next = 7'b1111111;
    dp_next = 1'b1;
    if (slot_reg == 2'd2)
      dp_next = running ? blink_phase_reg : 1'b0;
  end

  // Register the display outputs. They trail the counter/slot state by one clock.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      an  <= 4'b1111;
      seg <= 7'b1111111;
      dp  <= 1'b1;
    end else begin
      an  <= an_next;
      seg <= seg_next;
      dp  <= dp_next;
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized self-checking bench for display_scan.
// The reference model uses only the elapsed clock count since reset. From
// it the model derives the expected counter value, slot, frame number and
// blink phase. The expected digits come from per-frame snapshots that the
// model records itself.
module tb_display_scan;

  localparam int D  = 8;
  localparam int BD = 2;
  localparam int FR = 4 * D;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] s0 = 4'd0, s1 = 4'd0, m0 = 4'd0, m1 = 4'd0;
  logic       running = 1'b0;
  logic       blank_lead = 1'b0;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;
  logic       frame_done;

  int checks = 0;
  int errors = 0;
  int n = 0;                 // posedges since reset release
  logic [15:0] snaps [0:63]; // {m1,m0,s1,s0} shown in each frame
  logic [6:0]  font  [0:15];

  display_scan #(.REFRESH_DIV(D), .BLINK_DIV(BD)) dut (
    .clk(clk), .reset(reset),
    .s0(s0), .s1(s1), .m0(m0), .m1(m1),
    .running(running), .blank_lead(blank_lead),
    .an(an), .seg(seg), .dp(dp), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at n=%0d: got %0h expected %0h", tag, n, got, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_an"},  16'(an),  16'hF);
    check({tag, "_seg"}, 16'(seg), 16'h7F);
    check({tag, "_dp"},  16'(dp),  16'h1);
    check({tag, "_fd"},  16'(frame_done), 16'h0);
  endtask

  // One clock: record what the DUT sees at this edge, then compare.
  task automatic run_cycle();
    int j, c, s, f, phase;
    logic [15:0] snap;
    logic [3:0] dig;
    logic [3:0] e_an;
    logic [6:0] e_seg;
    logic e_dp, run_e, bl_e;
    @(posedge clk);
    n++;
    run_e = running;
    bl_e  = blank_lead;
    if (n % FR == 0) snaps[n / FR] = {m1, m0, s1, s0};
    #1;
    // The outputs registered at edge n reflect the state from before that edge.
    j = n - 1;
    c = j % D;
    s = (j / D) % 4;
    f = j / FR;
    phase = (f / BD) % 2;
    snap = snaps[f];
    dig = snap[4*s +: 4];
    e_an = (c < 2) ? 4'hF : ~(4'b0001 << s);
    e_seg = font[dig];
    if (s == 3 && bl_e && dig == 4'd0) e_seg = 7'h7F;
    e_dp = (s == 2) ? (run_e ? phase[0] : 1'b0) : 1'b1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("dp", 16'(dp), 16'(e_dp));
    check("frame_done", 16'(frame_done), 16'((n % FR) == FR - 1));
  endtask

  task automatic clear_model();
    n = 0;
    for (int i = 0; i < 64; i++) snaps[i] = 16'h0;
  endtask

  task automatic random_stim();
    int k;
    if ($urandom_range(0, 7) == 0) begin
      k = $urandom_range(0, 3);
      case (k)
        0: s0 = 4'($urandom_range(0, 15));
        1: s1 = 4'($urandom_range(0, 15));
        2: m0 = 4'($urandom_range(0, 15));
        default: m1 = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      endcase
    end
    if ($urandom_range(0, 39) == 0) running = ~running;
    if ($urandom_range(0, 29) == 0) blank_lead = ~blank_lead;
  endtask

  initial begin
    font[0] = 7'b1000000; font[1] = 7'b1111001; font[2] = 7'b0100100;
    font[3] = 7'b0110000; font[4] = 7'b0011001; font[5] = 7'b0010010;
    font[6] = 7'b0000010; font[7] = 7'b1111000; font[8] = 7'b0000000;
    font[9] = 7'b0010000;
    for (int i = 10; i < 16; i++) font[i] = 7'b0111111;
    clear_model();

    // Check the outputs while reset is held.
    s0 = 4'd1; s1 = 4'd2; m0 = 4'd3; m1 = 4'd4; running = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset_hold");

    // Fixed digits 1,2,3,4 with running=1: frame 0 shows zeros, later
    // frames show the digits, and dp blinks every two frames.
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 6 * FR; i++) begin
      run_cycle();
      @(negedge clk);
    end

    // Directed cases: a zero leading digit with blanking, a dash from m0,
    // then the same display without blanking.
    m1 = 4'd0; m0 = 4'hC; blank_lead = 1'b1; running = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      run_cycle();
      @(negedge clk);
    end
    blank_lead = 1'b0;
    for (int i = 0; i < 2 * FR; i++) begin
      run_cycle();
      @(negedge clk);
    end

    // Random mid-frame changes to the digits, running and blank_lead.
    for (int i = 0; i < 10 * FR; i++) begin
      random_stim();
      run_cycle();
      @(negedge clk);
    end

    // Run until the DUT should be in slot 2 at count 5, then assert reset
    // in the middle of the cycle.
    for (int i = 0; i < 2 * FR; i++) begin
      run_cycle();
      if ((n % D) == 5 && ((n / D) % 4) == 2) break;
      @(negedge clk);
    end
    check("reset_target_slot", 16'((n / D) % 4), 16'd2);
    reset = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset_held");
    @(negedge clk);
    clear_model();
    reset = 1'b1;
    for (int i = 0; i < 3 * FR; i++) begin
      random_stim();
      run_cycle();
      @(negedge clk);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_scan.md
DISPLAY_SCAN -- requirements
Module: display_scan

Interface
REQ-001 Parameter REFRESH_DIV, default 50000: clocks per digit slot; legal range >= 4.
REQ-002 Parameter BLINK_DIV, default 125: frames per half-period of the dp blink; legal range >= 1.
REQ-003 Port clk  input  1  single system clock; all state SHALL update on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
REQ-005 Port s0, s1, m0, m1  input  4 each  BCD digits from the digit blocks (seconds units, seconds tens, minutes units, minutes tens).
REQ-006 Port running  input  1  1 = stopwatch counting; selects the dp mode.
REQ-007 Port blank_lead  input  1  1 = blank m1 when it is zero.
REQ-008 Port an  output  4  digit anodes, active-low; an[0] drives s0 and an[3] drives m1.
REQ-009 Port seg  output  7  segments {g,f,e,d,c,b,a}, active-low.
REQ-010 Port dp  output  1  decimal point, active-low.
REQ-011 Port frame_done  output  1  one-clock pulse at the end of each 4-digit frame.

Function
REQ-012 Refresh counter SHALL count 0..REFRESH_DIV-1, wrap to 0, and advance slot index 0->1->2->3->0 on each wrap.
REQ-013 On the wrap from slot 3 to slot 0, s0, s1, m0 and m1 SHALL be captured into a snapshot; all four digits of a frame SHALL come from one snapshot.
REQ-014 frame_done SHALL be 1 for exactly the clock in which the slot 3->0 wrap and the snapshot capture occur.
REQ-015 an, seg and dp SHALL be registered outputs reflecting the current slot one clock after the counter/index state.
REQ-016 Guard: while the refresh counter is 0 or 1, an SHALL be 4'b1111; otherwise exactly one an bit, the current slot's, SHALL be 0.
REQ-017 Decoder: values 0-9 SHALL produce standard 7-segment patterns (e.g. 0 -> 7'b1000000, 8 -> 7'b0000000); values 10-15 SHALL produce dash 7'b0111111.
REQ-018 Blanking: in slot 3, when blank_lead=1 and snapshot m1=0, seg SHALL be 7'b1111111 (an unaffected).
REQ-019 dp SHALL be driven 0 (lit) only in slot 2; in all other slots dp=1.
REQ-020 Blink: a frame counter SHALL count frame_done pulses 0..BLINK_DIV-1 and toggle blink_phase on each wrap.
REQ-021 Slot-2 dp: running=0 -> steady lit; running=1 -> lit when blink_phase=0, dark when blink_phase=1.
REQ-022 A change of running SHALL take effect at the next slot-2 output update, with no effect on the counters.
REQ-023 Inputs changing mid-frame SHALL NOT alter the displayed frame; the change appears from the next frame.

Reset
REQ-024 While reset=0: refresh counter=0, slot=0, frame counter=0, blink_phase=0, snapshot=0, an=4'b1111, seg=7'b1111111, dp=1, frame_done=0.
REQ-025 After reset releases, the first frame SHALL display the all-zero snapshot; live inputs SHALL first be captured at the first 3->0 wrap.
REQ-026 Reset asserted mid-frame SHALL immediately force the REQ-024 values; scanning restarts from slot 0, counter 0.

Verification (REFRESH_DIV=8, BLINK_DIV=2)
REQ-027 Release reset, hold inputs 1,2,3,4 -> frame 1 all slots 7'b1000000; from frame 2 slot 0 shows 1 (7'b1111001) and slot 3 shows 4 (7'b0011001); frame_done every 32 clocks.
REQ-028 Check each slot -> an=4'b1111 for counter values 0-1, then the single slot bit low for counter values 2-7; never two an bits low.
REQ-029 m1=0 with blank_lead=1 -> slot 3 seg=7'b1111111; blank_lead=0 -> 7'b1000000; m0=4'hC -> slot 2 shows dash 7'b0111111.
REQ-030 running=1 -> slot-2 dp lit for 2 frames, dark for 2 frames, repeating; running=0 -> slot-2 dp always lit; dp=1 in slots 0, 1 and 3.
REQ-031 Change s0 mid-frame -> displayed s0 unchanged until after the next frame_done.
REQ-032 Assert reset in slot 2, counter 5 -> outputs take REQ-024 values within the same cycle; after release, scanning restarts at slot 0, counter 0.
